// File: rtl/dram_tx_pkg.sv
// Shared types and sizing helpers for the DRAM-to-serial streamer.
// The checksum frame build is selected with the TX_CHECKSUM_EN macro.
package dram_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
`ifdef TX_CHECKSUM_EN
        ST_CSUM  = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

    // One start bit, the data bits, one stop bit.
    function automatic int frame_bits(input int data_w);
        return data_w + 2;
    endfunction

    // Width able to hold the pixel count up to and including NUM_PIXELS.
    function automatic int cnt_width(input int num_pixels);
        return $clog2(num_pixels + 1);
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1-style frame transmitter: start bit, DATA_W bits LSB first, stop bit.
// frame_done pulses for one cycle during the last cycle of the stop bit.
module uart_tx_frame
    import dram_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              frame_done
);

    localparam int FB     = frame_bits(DATA_W);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(FB);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FB - 1);

    // Remaining bits after the start bit: data then stop, shifted out LSB first.
    logic              active_q, active_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [FB-2:0]     frame_q, frame_d;
    logic              tx_q, tx_d;

    // Next-state logic for the baud counter, bit counter and shifter.
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        tx_d     = tx_q;
        if (load) begin
            active_d = 1'b1;
            baud_d   = {BAUD_W{1'b0}};
            bit_d    = {BIT_W{1'b0}};
            frame_d  = {1'b1, data};
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = {BAUD_W{1'b0}};
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + BIT_W'(1);
                    tx_d    = frame_q[0];
                    frame_d = {1'b1, frame_q[FB-2:1]};
                end
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end else begin
            tx_d = 1'b1;
        end
    end

    // Frame state registers; the line idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            baud_q   <= {BAUD_W{1'b0}};
            bit_q    <= {BIT_W{1'b0}};
            frame_q  <= {(FB-1){1'b1}};
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            tx_q     <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign frame_done = active_q & (baud_q == BAUD_LAST) & (bit_q == BIT_LAST);

endmodule

// File: rtl/dram_tx_streamer.sv
// Streams NUM_PIXELS DRAM words from BASE_ADDR out as serial frames on a
// rising edge of start; passes processor DRAM traffic through while idle.
// Define TX_CHECKSUM_EN to append a modulo-2^DATA_W sum frame.
module dram_tx_streamer
    import dram_tx_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = {ADDR_W{1'b0}},
    parameter int                NUM_PIXELS   = 16384,
    parameter int                CLKS_PER_BIT = 434,
    parameter int                READ_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              proc_wren,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_wren,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width(NUM_PIXELS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIXELS - 1);
    localparam logic [1:0]       LAT_LAST = 2'(READ_LAT - 1);

    state_e            state_q, state_d;
    logic              start_q;
    logic              armed_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic              load_s;
    logic [DATA_W-1:0] load_data_s;
    logic              frame_done_s;
    logic              launch_s;
`ifdef TX_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // armed_q keeps a start level already high at reset release from
    // looking like a rising edge on the first clock.
    assign launch_s = start & ~start_q & armed_q;

    // Transfer sequencing: next state, address/counter updates, frame loads.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        load_s      = 1'b0;
        load_data_s = dram_rdata;
`ifdef TX_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d = ST_FETCH;
                    addr_d  = BASE_ADDR;
                    cnt_d   = {CNT_W{1'b0}};
                    lat_d   = 2'd0;
`ifdef TX_CHECKSUM_EN
                    sum_d   = {DATA_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    load_s  = 1'b1;
                    lat_d   = 2'd0;
                    state_d = ST_SEND;
`ifdef TX_CHECKSUM_EN
                    sum_d   = sum_q + dram_rdata;
`endif
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_SEND: begin
                if (frame_done_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
`ifdef TX_CHECKSUM_EN
                        // Sum frame starts straight after the last stop bit.
                        state_d     = ST_CSUM;
                        load_s      = 1'b1;
                        load_data_s = sum_q;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
`ifdef TX_CHECKSUM_EN
            ST_CSUM: begin
                if (frame_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, start edge history and transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            lat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            armed_q <= 1'b1;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

`ifdef TX_CHECKSUM_EN
    // Running sum of every word latched during the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= {DATA_W{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // DRAM port ownership follows the registered state; processor writes
    // are dropped while the streamer owns the port.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        dram_addr  = proc_addr;
        dram_wren  = proc_wren;
        dram_wdata = proc_wdata;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy      = 1'b1;
                dram_addr = addr_q;
                dram_wren = 1'b0;
            end
        endcase
    end

    uart_tx_frame #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .data       (load_data_s),
        .tx         (tx),
        .frame_done (frame_done_s)
    );

endmodule
